// File: rtl/cp_mc_write_ram_pkg.sv
// Shared types and helpers for the multi-channel RAM write controller.
// Holds the FSM state encoding, error bit positions and address-span arithmetic.
package cp_write_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int unsigned ERR_LEN = 0;
    localparam int unsigned ERR_OVF = 1;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint unsigned ch_span(input int unsigned data_num,
                                                input int unsigned add_addr);
        return longint'(data_num) * longint'(add_addr);
    endfunction

    function automatic longint unsigned bank_span(input int unsigned num_ch,
                                                  input int unsigned data_num,
                                                  input int unsigned add_addr);
        return longint'(num_ch) * ch_span(data_num, add_addr);
    endfunction

endpackage

// File: rtl/cp_mc_write_ram_delay.sv
// Fixed-depth register delay line with asynchronous active-low reset.
// DEPTH = 0 degenerates to a plain wire.
module delay_data #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign dout = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cp_mc_write_ram.sv
// Multi-channel frame-based RAM write controller: per-channel regions with ping-pong banks,
// per-channel frame length checking and a completion pulse once the last write has left.
module cp_mc_write_ram
    import cp_write_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_NUM   = 1024,
    parameter int unsigned ADD_ADDR   = 16,
    parameter int unsigned PIPE_DLY   = 2,
    parameter int unsigned PING_PONG  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [ADDR_WIDTH-1:0]           i_cfg_base,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic                            i_data_valid,
    input  logic                            i_data_last,
    input  logic [id_width(NUM_CH)-1:0]     i_data_ch,
    input  logic [DATA_WIDTH/8-1:0]         i_data_strb,
    output logic [DATA_WIDTH-1:0]           o_wr_data,
    output logic [ADDR_WIDTH-1:0]           o_wr_addr,
    output logic                            o_wr_en,
    output logic [DATA_WIDTH/8-1:0]         o_wr_wea,
    output logic                            o_busy,
    output logic                            o_bank,
    output logic                            o_finish,
    output logic [1:0]                      o_err
);

    localparam int unsigned CH_W     = id_width(NUM_CH);
    localparam int unsigned CNT_W    = id_width(DATA_NUM);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned FLUSH_W  = id_width(PIPE_DLY);
    localparam int unsigned BUNDLE_W = 1 + ADDR_WIDTH + STRB_W;

    localparam logic [ADDR_WIDTH-1:0] CH_SPAN   = ADDR_WIDTH'(ch_span(DATA_NUM, ADD_ADDR));
    localparam logic [ADDR_WIDTH-1:0] BANK_SPAN = ADDR_WIDTH'(bank_span(NUM_CH, DATA_NUM, ADD_ADDR));
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADD_ADDR);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DATA_NUM - 1);
    localparam logic [FLUSH_W-1:0]    FLUSH_END = FLUSH_W'(PIPE_DLY - 1);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  base;
    logic                   bank;
    logic [NUM_CH-1:0]      done;
    logic [CNT_W-1:0]       cnt [NUM_CH];
    logic [FLUSH_W-1:0]     flush_cnt;

    logic [CH_W-1:0]        ch;
    logic [CNT_W-1:0]       cur_cnt;
    logic [NUM_CH-1:0]      ch_bit;
    logic                   beat_ok;
    logic                   beat_drop;
    logic                   at_last;
    logic                   completes;
    logic                   len_err;
    logic                   all_done_next;
    logic [ADDR_WIDTH-1:0]  beat_addr;

    always_comb begin
        ch            = i_data_ch;
        cur_cnt       = cnt[ch];
        ch_bit        = '0;
        ch_bit[ch]    = 1'b1;
        beat_ok       = (state == ST_RUN) && i_data_valid && !done[ch];
        beat_drop     = (state == ST_RUN) && i_data_valid && done[ch];
        at_last       = (cur_cnt == CNT_LAST);
        completes     = i_data_last || at_last;
        len_err       = i_data_last != at_last;
        all_done_next = &(done | ch_bit);
        beat_addr     = base + ADDR_WIDTH'(ch) * CH_SPAN + (bank ? BANK_SPAN : '0)
                      + ADDR_WIDTH'(cur_cnt) * STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            base      <= '0;
            bank      <= 1'b0;
            done      <= '0;
            flush_cnt <= '0;
            o_busy    <= 1'b0;
            o_finish  <= 1'b0;
            o_err     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            o_finish <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state  <= ST_RUN;
                        base   <= i_cfg_base;
                        done   <= '0;
                        o_err  <= '0;
                        o_busy <= 1'b1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat_drop) begin
                        o_err[ERR_OVF] <= 1'b1;
                    end
                    if (beat_ok) begin
                        if (len_err) begin
                            o_err[ERR_LEN] <= 1'b1;
                        end
                        // A completing beat freezes the counter so it keeps the final index.
                        if (completes) begin
                            done[ch] <= 1'b1;
                        end else begin
                            cnt[ch] <= cur_cnt + 1'b1;
                        end
                        if (completes && all_done_next) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_END) begin
                        state    <= ST_DONE;
                        o_finish <= 1'b1;
                        o_busy   <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (PING_PONG != 0) begin
                        bank <= ~bank;
                    end
                end
            endcase
        end
    end

    assign o_bank = bank;

    logic [DATA_WIDTH-1:0] s1_data;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s1_en;
    logic [STRB_W-1:0]     s1_wea;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data <= '0;
            s1_addr <= '0;
            s1_en   <= 1'b0;
            s1_wea  <= '0;
        end else begin
            s1_data <= i_data;
            s1_en   <= beat_ok;
            s1_addr <= beat_ok ? beat_addr : '0;
            s1_wea  <= beat_ok ? i_data_strb : '0;
        end
    end

    logic [BUNDLE_W-1:0] ctl_out;

    delay_data #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (PIPE_DLY - 1)
    ) u_dly_data (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (s1_data),
        .dout  (o_wr_data)
    );

    delay_data #(
        .WIDTH (BUNDLE_W),
        .DEPTH (PIPE_DLY - 1)
    ) u_dly_ctl (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({s1_en, s1_addr, s1_wea}),
        .dout  (ctl_out)
    );

    assign {o_wr_en, o_wr_addr, o_wr_wea} = ctl_out;

endmodule
